alu_multicycle: RTL
===================

Name: alu_multicycle

Overview:
Parametrised next-generation ALU for the WISC datapath. It generalises the 16-bit combinational ALU to WIDTH bits and adds a valid/ready handshake, a registered result with a one-entry output buffer, and a flags register. It also adds an iterative shift-add multiplier (MUL) that takes WIDTH cycles. It sits in the EX stage; the hazard/stall logic uses in_ready and busy to stall upstream.

Parameters:
WIDTH, 16, datapath width; power of two, >= 8.
LANE, 4, sub-word lane width for PADDS; must divide WIDTH, >= 2.
SHW, $clog2(WIDTH), derived shift-amount width; not overridden.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
in_valid  in  1  operation request.
in_ready  out  1  block can accept an operation this cycle.
opcode  in  4  operation select.
a  in  WIDTH  operand 1.
b  in  WIDTH  operand 2.
out_valid  out  1  result register holds an unconsumed result.
out_ready  in  1  downstream takes the result.
result  out  WIDTH  registered result.
flags  out  3  {Z,V,N} flags register.
busy  out  1  MUL in progress.

Behaviour:
- Reset (rst=0, async): state=IDLE, out_valid=0, result=0, flags=3'b000, busy=0, MUL counter/accumulator cleared. Reset mid-MUL aborts the operation; no result is ever produced for it.
- Accept: an operation is accepted on an edge where in_valid & in_ready. in_ready = (state==IDLE) & (~out_valid | out_ready).
- Output slot: out_valid is cleared on an edge where out_valid & out_ready, unless a new result is written on that same edge, in which case out_valid stays 1 with the new result. result holds its value while out_valid & ~out_ready.
- Single-cycle ops, result written on the accept edge (latency 1):
  - 0000 ADD, 0001 SUB: two's complement (SUB = a + ~b + 1), saturating. Overflow gives max positive 0111..1 if the pre-saturation sign is 1, else min negative 100..0. Z = (result==0), V = overflow, N = result[WIDTH-1] after saturation.
  - 0010 XOR: Z only; V=N=0.
  - 0011 PADDS: per-LANE signed saturating add with no carry between lanes; each lane saturates to 01..1 / 10..0. Flags not updated.
  - 0100 SLL, 0101 SRA, 0110 ROR: shift amount is b[SHW-1:0]; amount 0 passes a. Z only; V=N=0.
  - 1000-1111: result = a (passthrough, used for PCS etc.). Flags not updated.
- MUL (0111): unsigned; result = low WIDTH bits of a*b.
  - Accept edge: go to MUL, busy=1, mcand={WIDTH'b0,a} (2*WIDTH bits), mplier=b, acc=0, cnt=0.
  - Each MUL cycle: if mplier[0], acc += mcand; mcand <<= 1; mplier >>= 1; cnt++.
  - On the edge where cnt==WIDTH-1: write the final acc[WIDTH-1:0] to result, set out_valid=1, go to IDLE, busy=0. out_valid therefore rises exactly WIDTH edges after the accept edge.
  - Flags: Z = (result==0), V = |acc[2*WIDTH-1:WIDTH] (unsigned overflow), N = result[WIDTH-1].
  - in_ready=0 throughout MUL. The output slot is guaranteed free at completion, because acceptance required it and nothing else writes it.
- Flags update: on the same edge that writes result, only for ops that update flags. flags changes in the same cycle out_valid rises.
- States: IDLE -> MUL (accept with opcode 0111); MUL -> IDLE (cnt==WIDTH-1). Any other opcode stays in IDLE.
- Boundary conditions:
  - opcode/a/b are ignored when not accepted.
  - A new accept on the same edge the old result is consumed is legal; back-to-back single-cycle ops sustain one per cycle.
  - Reset asserted during stalled output: result is lost, out_valid=0.

Test Plan:
- WIDTH=16: ADD a=0x7FFF, b=0x0001 -> result 0x7FFF, flags ZVN=010, out_valid 1 cycle after accept; then SUB 0x0005-0x0005 -> 0x0000, ZVN=100.
- PADDS a=0x7777, b=0x1111 after the SUB -> 0x7777 (all lanes saturate), flags remain 100; PADDS 0x8421+0xF0F0 -> 0x8411.
- SRA a=0x8000, b=0x000F -> 0xFFFF, ZVN=000; ROR a=0x0001, b=0x0004 -> 0x1000; SLL a=0x00FF, b=0x0008 -> 0xFF00.
- MUL a=0x0100, b=0x0100 -> result 0x0000, ZVN=110, out_valid exactly 16 edges after accept, busy=1 and in_ready=0 for those 16 cycles; MUL 0x00FF*0x0003 -> 0x02FD, ZVN=000.
- Backpressure: out_ready=0, ADD 3+4 -> result 0x0007 held, in_ready=0, second request (XOR) not accepted; raise out_ready -> XOR accepted on the same edge, result replaced next cycle with out_valid continuously 1.
- Assert rst low at cycle 5 of a MUL -> out_valid=0, busy=0, flags=000 immediately (asynchronously); after release in_ready=1 and no stale MUL result ever appears.

Source files
------------

// File: rtl/alu_multicycle.sv
// alu_multicycle: WIDTH-bit EX-stage ALU with a valid/ready request side,
// a registered one-entry result slot, a {Z,V,N} flags register and an
// iterative shift-add multiplier that occupies the block for WIDTH cycles.
//
// Handshake: a request is taken on a rising edge where in_valid & in_ready;
// a result is handed off on a rising edge where out_valid & out_ready. The
// requester may not assume acceptance until it sees in_ready high at the edge,
// and result/flags stay stable while out_valid is high and out_ready is low.
module alu_multicycle #(
  parameter int WIDTH = 16,
  parameter int LANE  = 4,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags,
  output logic             busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_PAD = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b0111;

  state_t               state_q, state_d;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     result_q;
  logic [2:0]           flags_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [SHW-1:0]       cnt_q;

  logic                 accept;
  logic                 is_mul_op;
  logic                 sc_write;
  logic                 mul_last;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]     sc_result;
  logic [2:0]           sc_flags;
  logic [2:0]           mul_flags;

  // Arithmetic helpers for the single-cycle ops
  logic                 is_sub;
  logic [WIDTH-1:0]     b_eff;
  logic [WIDTH-1:0]     add_raw;
  logic                 add_ovf;
  logic [WIDTH-1:0]     add_res;
  logic [WIDTH-1:0]     xor_res;
  logic [WIDTH-1:0]     padds_res;
  logic [SHW-1:0]       shamt;
  logic [WIDTH-1:0]     sll_res;
  logic [WIDTH-1:0]     sra_res;
  logic [2*WIDTH-1:0]   ror_full;
  logic [WIDTH-1:0]     ror_res;

  assign in_ready  = (state_q == S_IDLE) & (~out_valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign is_mul_op = (opcode == OP_MUL);
  assign sc_write  = accept & ~is_mul_op;
  assign mul_last  = (state_q == S_MUL) & (cnt_q == SHW'(WIDTH - 1));
  assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign busy      = (state_q == S_MUL);

  // SUB is a + ~b + 1; overflow when both addends share a sign the sum lacks.
  assign is_sub  = (opcode == OP_SUB);
  assign b_eff   = is_sub ? ~b : b;
  assign add_raw = a + b_eff + WIDTH'(is_sub);
  assign add_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) & (add_raw[WIDTH-1] != a[WIDTH-1]);
  assign add_res = !add_ovf ? add_raw :
                   add_raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};

  assign xor_res = a ^ b;

  // Lane-wise saturating add; no carry crosses a lane boundary.
  for (genvar g = 0; g < WIDTH / LANE; g++) begin : g_lane
    logic [LANE-1:0] la, lb, ls;
    logic            lovf;
    assign la   = a[g*LANE +: LANE];
    assign lb   = b[g*LANE +: LANE];
    assign ls   = la + lb;
    assign lovf = (la[LANE-1] == lb[LANE-1]) & (ls[LANE-1] != la[LANE-1]);
    assign padds_res[g*LANE +: LANE] = !lovf ? ls :
      ls[LANE-1] ? {1'b0, {(LANE-1){1'b1}}} : {1'b1, {(LANE-1){1'b0}}};
  end

  assign shamt    = b[SHW-1:0];
  assign sll_res  = a << shamt;
  assign sra_res  = $signed(a) >>> shamt;
  assign ror_full = {a, a} >> shamt;
  assign ror_res  = ror_full[WIDTH-1:0];

  assign mul_flags = {(acc_step[WIDTH-1:0] == '0), |acc_step[2*WIDTH-1:WIDTH], acc_step[WIDTH-1]};

  // Single-cycle result and flag select; ops that leave flags alone keep flags_q
  always_comb begin
    sc_result = a;
    sc_flags  = flags_q;
    case (opcode)
      OP_ADD, OP_SUB: begin
        sc_result = add_res;
        sc_flags  = {(add_res == '0), add_ovf, add_res[WIDTH-1]};
      end
      OP_XOR: begin
        sc_result = xor_res;
        sc_flags  = {(xor_res == '0), 2'b00};
      end
      OP_PAD: sc_result = padds_res;
      OP_SLL: begin
        sc_result = sll_res;
        sc_flags  = {(sll_res == '0), 2'b00};
      end
      OP_SRA: begin
        sc_result = sra_res;
        sc_flags  = {(sra_res == '0), 2'b00};
      end
      OP_ROR: begin
        sc_result = ror_res;
        sc_flags  = {(ror_res == '0), 2'b00};
      end
      default: sc_result = a;
    endcase
  end

  // Next-state logic: only MUL leaves IDLE, and it returns after WIDTH steps
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && is_mul_op) state_d = S_MUL;
      S_MUL:  if (mul_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Multiplier datapath: load on accept, one shift-add step per MUL cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == S_IDLE && accept && is_mul_op) begin
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == S_MUL) begin
      acc_q    <= acc_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  // Output slot: a new result wins over a same-edge consume
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= 3'b000;
    end else if (sc_write) begin
      out_valid_q <= 1'b1;
      result_q    <= sc_result;
      flags_q     <= sc_flags;
    end else if (mul_last) begin
      out_valid_q <= 1'b1;
      result_q    <= acc_step[WIDTH-1:0];
      flags_q     <= mul_flags;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
